// File: rtl/cprv_dmem_pkg.sv
// cprv_dmem_pkg: shared FSM state type and sizing helper for the data-memory responder
package cprv_dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction
endpackage

// File: rtl/cprv_dmem_if.sv
// cprv_dmem_if: mem-stage <-> dmem request and response channels
interface cprv_dmem_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid_dmem_i;
    logic                  ready_dmem_o;
    logic [DATA_WIDTH-1:0] addr_dmem_i;
    logic [DATA_WIDTH-1:0] wdata_dmem_i;
    logic                  w_en_dmem_i;
    logic                  valid_mem_dmem_o;
    logic                  ready_mem_dmem_i;
    logic [DATA_WIDTH-1:0] rdata_dmem_o;

    modport master (
        output valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
        input  ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o
    );

    modport slave (
        input  valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
        output ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o
    );
endinterface

// File: rtl/cprv_dmem_ram.sv
// cprv_dmem_ram: single-port synchronous doubleword RAM with registered read data
module cprv_dmem_ram
    import cprv_dmem_pkg::*;
#(
    parameter int    DATA_WIDTH  = 64,
    parameter int    DEPTH_WORDS = 4096,
    parameter string INIT_FILE   = "",
    parameter int    IW          = idx_width(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IW-1:0]         idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[idx] <= wdata;
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/cprv_dmem.sv
// cprv_dmem: latency-modelled doubleword data memory answering one mem-stage request at a time
module cprv_dmem
    import cprv_dmem_pkg::*;
#(
    parameter int    DATA_WIDTH  = 64,
    parameter int    DEPTH_WORDS = 4096,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input logic        clk,
    input logic        rst,
    cprv_dmem_if.slave bus
);
    localparam int IW = idx_width(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] wdata_q, ram_rdata;
    logic                  w_q, accept, access, ram_en;

    assign bus.ready_dmem_o = state == IDLE || (state == RESP && bus.ready_mem_dmem_i);
    assign accept = bus.valid_dmem_i && bus.ready_dmem_o && !rst;
    assign access = state == BUSY && cnt == '0;
    // a reset landing on the access edge must suppress the write
    assign ram_en = access && !rst;

    always_comb begin
        state_d = state;
        cnt_d   = accept ? CW'(LATENCY - 1) : (state == BUSY && !access) ? cnt - 1'b1 : cnt;
        case (state)
            IDLE:    state_d = accept ? BUSY : IDLE;
            BUSY:    state_d = access ? RESP : BUSY;
            RESP:    state_d = bus.ready_mem_dmem_i ? (accept ? BUSY : IDLE) : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
        if (accept) begin
            idx_q   <= bus.addr_dmem_i[3 +: IW];
            wdata_q <= bus.wdata_dmem_i;
            w_q     <= bus.w_en_dmem_i;
        end
    end

    cprv_dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (w_q),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // the RAM output register only moves on an access edge, so it holds through a stall
    assign bus.valid_mem_dmem_o = state == RESP;
    assign bus.rdata_dmem_o     = (state == RESP && !w_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_cprv_dmem.sv
// tb_cprv_dmem: directed bench for two cprv_dmem configurations against a transaction-level model
module tb_cprv_dmem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel, valid, we, rm, chk_en;
    logic [63:0] addr, wdata;
    logic        ready_o, valid_o;
    logic [63:0] rdata_o;
    int          n_cmp = 0, n_err = 0;

    cprv_dmem_if #(.DATA_WIDTH(64)) if_a ();
    cprv_dmem_if #(.DATA_WIDTH(64)) if_b ();

    cprv_dmem #(.LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    cprv_dmem #(.DEPTH_WORDS(16), .LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.valid_dmem_i     = valid && !sel;
    assign if_b.valid_dmem_i     = valid && sel;
    assign if_a.addr_dmem_i      = addr;
    assign if_b.addr_dmem_i      = addr;
    assign if_a.wdata_dmem_i     = wdata;
    assign if_b.wdata_dmem_i     = wdata;
    assign if_a.w_en_dmem_i      = we;
    assign if_b.w_en_dmem_i      = we;
    assign if_a.ready_mem_dmem_i = rm;
    assign if_b.ready_mem_dmem_i = rm;
    assign ready_o = sel ? if_b.ready_dmem_o : if_a.ready_dmem_o;
    assign valid_o = sel ? if_b.valid_mem_dmem_o : if_a.valid_mem_dmem_o;
    assign rdata_o = sel ? if_b.rdata_dmem_o : if_a.rdata_dmem_o;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: one outstanding request, visible LATENCY edges after acceptance, memory per instance
    bit [63:0]   mm [2][4096];
    bit          out, m_w;
    int          acc_e, cyc = 0;
    logic [11:0] m_idx;
    logic [63:0] m_wd, exp_rd;

    function automatic int lat();
        return sel ? 3 : 1;
    endfunction
    function automatic logic [11:0] ix(input logic [63:0] a);
        return sel ? {8'h0, a[6:3]} : a[14:3];
    endfunction
    function automatic bit vexp();
        return out && cyc >= acc_e + lat();
    endfunction
    function automatic bit rexp();
        return !out || (vexp() && rm);
    endfunction

    always @(posedge clk) begin
        bit v, r;
        v = vexp();
        r = rexp();
        if (rst) out = 1'b0;
        else begin
            if (out && cyc + 1 == acc_e + lat()) begin
                if (m_w) mm[sel][m_idx] = m_wd;
                exp_rd = m_w ? 64'h0 : mm[sel][m_idx];
            end
            if (v && rm) out = 1'b0;
            if (valid && r) begin
                out = 1'b1; acc_e = cyc + 1; m_w = we; m_idx = ix(addr); m_wd = wdata;
            end
        end
        cyc++;
    end

    int          rq[$];
    logic [63:0] rdq[$];

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("valid", {63'h0, valid_o}, {63'h0, vexp()});
            chk("ready", {63'h0, ready_o}, {63'h0, rexp()});
            if (vexp()) chk("rdata", rdata_o, exp_rd);
            if (valid_o && rm) begin
                rq.push_back(cyc);
                rdq.push_back(rdata_o);
            end
        end
    end

    task automatic req(input logic [63:0] a, input logic [63:0] d, input logic w, output int waited);
        bit hs;
        valid = 1'b1; addr = a; wdata = d; we = w; waited = 0;
        do begin
            @(negedge clk);
            hs = ready_o;
            @(posedge clk); #1;
            waited++;
        end while (!hs && waited < 30);
        if (!hs) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: addr %h not accepted within 30 cycles", a);
        end
        valid = 1'b0;
    endtask

    task automatic rsp(output logic [63:0] d, output int k);
        k = 0;
        @(negedge clk);
        while (!valid_o && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!valid_o) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_timeout: no response within 30 cycles");
        end
        d = rdata_o;
        @(posedge clk); #1;
    endtask

    task automatic txn(input logic [63:0] a, input logic [63:0] d, input logic w,
                       output logic [63:0] rd, output int k);
        int wt;
        req(a, d, w, wt);
        rsp(rd, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        int          k, wt, seen;
        logic [63:0] b2b_addr [4] = '{64'h00, 64'h08, 64'h10, 64'h18};
        logic [63:0] b2b_exp  [4] = '{64'h11, 64'h0123_4567_89AB_CDEF, 64'hA1, 64'hA2};
        sel = 1'b0; valid = 1'b0; addr = '0; wdata = '0; we = 1'b0; rm = 1'b1; chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", {63'h0, ready_o}, 64'h1);
        chk("reset_valid", {63'h0, valid_o}, 64'h0);
        chk("reset_rdata", rdata_o, 64'h0);
        @(posedge clk); #1;

        txn(64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, rd, k);
        chk("store_rdata", rd, 64'h0);
        chk("store_lat", 64'(k), 64'd1);
        txn(64'h40, 64'h0, 1'b0, rd, k);
        chk("load40_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        chk("load40_lat", 64'(k), 64'd1);

        rm = 1'b0;
        req(64'h40, 64'h0, 1'b0, wt);
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'h0, valid_o}, 64'h1);
            chk("stall_rdata", rdata_o, 64'hDEAD_BEEF_CAFE_F00D);
            chk("stall_ready", {63'h0, ready_o}, 64'h0);
            @(posedge clk); #1;
        end
        rm = 1'b1;
        req(64'h47, 64'h0, 1'b0, wt);
        chk("same_edge_accept", 64'(wt), 64'd1);
        rsp(rd, k);
        chk("load47_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);

        sel = 1'b1;
        txn(64'h08, 64'h0123_4567_89AB_CDEF, 1'b1, rd, k);
        chk("b_store_lat", 64'(k), 64'd3);
        txn(64'h80, 64'h11, 1'b1, rd, k);
        txn(64'h00, 64'h0, 1'b0, rd, k);
        chk("wrap_rdata", rd, 64'h11);

        req(64'h08, 64'h55, 1'b1, wt);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_o) seen++;
            @(posedge clk); #1;
        end
        chk("dropped_resp", 64'(seen), 64'd0);
        txn(64'h08, 64'h0, 1'b0, rd, k);
        chk("dropped_store", rd, 64'h0123_4567_89AB_CDEF);

        txn(64'h10, 64'hA1, 1'b1, rd, k);
        txn(64'h18, 64'hA2, 1'b1, rd, k);
        rq.delete();
        rdq.delete();
        for (int i = 0; i < 4; i++) req(b2b_addr[i], 64'h0, 1'b0, wt);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_count", 64'(rq.size()), 64'd4);
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            chk("b2b_rdata", rdq[i], b2b_exp[i]);
            if (i > 0) chk("b2b_spacing", 64'(rq[i] - rq[i-1]), 64'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
